// File: rtl/dom_rnd_supplier.sv
// Fresh-randomness supplier for DOM-masked GF(2^2) multipliers: seeded 32-bit LFSR with warm-up.
// Optional repetition health check enabled by defining DOM_RND_HEALTH_EN.
module dom_rnd_supplier #(
  parameter int RND_W        = 4,
  parameter int WARMUP_CYC   = 16,
  parameter int REPEAT_LIMIT = 3
) (
  input  logic             ClkxCI,
  input  logic             RstxRI,
  input  logic [31:0]      SeedxDI,
  input  logic             SeedValidxSI,
  output logic             SeedReadyxSO,
  output logic [RND_W-1:0] RndxDO,
  output logic             RndValidxSO,
  input  logic             RndReadyxSI,
  output logic             ErrxSO
);

  typedef enum logic [1:0] {
    UNSEEDED,
    WARMUP,
    RUN
  } state_t;

  state_t      StatexDP, StatexDN;
  logic [31:0] LfsrxDP, LfsrxDN;
  logic [7:0]  WarmCntxDP, WarmCntxDN;

  logic        seedHs;
  logic        rndHs;
  logic        validInt;
  logic [31:0] seedVal;
  logic [31:0] lfsrAdv;

  function automatic logic [31:0] advance(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < RND_W; i++) begin
      t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    end
    return t;
  endfunction

  // an all-zero state would lock the LFSR up forever
  assign seedVal = (SeedxDI == 32'h0) ? 32'h1 : SeedxDI;
  assign lfsrAdv = advance(LfsrxDP);

  assign SeedReadyxSO = (StatexDP != WARMUP);
  assign seedHs       = SeedValidxSI & SeedReadyxSO;
  assign rndHs        = validInt & RndReadyxSI;
  assign RndValidxSO  = validInt;
  assign RndxDO       = LfsrxDP[RND_W-1:0];

  always_comb begin
    StatexDN   = StatexDP;
    LfsrxDN    = LfsrxDP;
    WarmCntxDN = WarmCntxDP;
    unique case (StatexDP)
      UNSEEDED: begin
        if (seedHs) begin
          LfsrxDN    = seedVal;
          WarmCntxDN = 8'd0;
          StatexDN   = WARMUP;
        end
      end
      WARMUP: begin
        LfsrxDN = lfsrAdv;
        if (WarmCntxDP == 8'(WARMUP_CYC - 1)) begin
          WarmCntxDN = 8'd0;
          StatexDN   = RUN;
        end else begin
          WarmCntxDN = WarmCntxDP + 8'd1;
        end
      end
      RUN: begin
        // a reseed wins; a concurrent consumer handshake still takes the word
        if (seedHs) begin
          LfsrxDN    = seedVal;
          WarmCntxDN = 8'd0;
          StatexDN   = WARMUP;
        end else if (rndHs) begin
          LfsrxDN = lfsrAdv;
        end
      end
      default: begin
        StatexDN = UNSEEDED;
      end
    endcase
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      StatexDP   <= UNSEEDED;
      LfsrxDP    <= 32'h1;
      WarmCntxDP <= 8'd0;
    end else begin
      StatexDP   <= StatexDN;
      LfsrxDP    <= LfsrxDN;
      WarmCntxDP <= WarmCntxDN;
    end
  end

`ifdef DOM_RND_HEALTH_EN
  logic [RND_W-1:0] PrevxDP, PrevxDN;
  logic [3:0]       RepCntxDP, RepCntxDN;
  logic             ErrxDP, ErrxDN;

  assign validInt = (StatexDP == RUN) & ~ErrxDP;
  assign ErrxSO   = ErrxDP;

  // a zero count means no word has been delivered yet
  always_comb begin
    PrevxDN   = PrevxDP;
    RepCntxDN = RepCntxDP;
    ErrxDN    = ErrxDP;
    if (rndHs) begin
      PrevxDN = RndxDO;
      if ((RepCntxDP != 4'd0) && (RndxDO == PrevxDP)) begin
        RepCntxDN = (RepCntxDP == 4'hF) ? RepCntxDP : RepCntxDP + 4'd1;
      end else begin
        RepCntxDN = 4'd1;
      end
      if (RepCntxDN == 4'(REPEAT_LIMIT)) begin
        ErrxDN = 1'b1;
      end
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      PrevxDP   <= '0;
      RepCntxDP <= 4'd0;
      ErrxDP    <= 1'b0;
    end else begin
      PrevxDP   <= PrevxDN;
      RepCntxDP <= RepCntxDN;
      ErrxDP    <= ErrxDN;
    end
  end
`else
  assign validInt = (StatexDP == RUN);
  // no health logic; the limit is always in range so the flag is constant 0
  assign ErrxSO   = (REPEAT_LIMIT > 15);
`endif

endmodule

// File: tb/tb_dom_rnd_supplier.sv
// Self-checking bench for dom_rnd_supplier: vector table plus reseed/reset/health sequences.
// Expected words come from an independent LFSR model through a scoreboard queue.
module tb_dom_rnd_supplier;

  logic        ClkxC = 1'b0;
  always #5 ClkxC = ~ClkxC;

  logic        rstA, seedValidA, seedReadyA, rndValidA, rndReadyA, errA;
  logic [31:0] seedA;
  logic [3:0]  rndA;

  logic        rstB, seedValidB, seedReadyB, rndValidB, rndReadyB, errB;
  logic [31:0] seedB;
  logic [0:0]  rndB;

  dom_rnd_supplier #(.RND_W(4), .WARMUP_CYC(16), .REPEAT_LIMIT(3)) dutA (
    .ClkxCI(ClkxC), .RstxRI(rstA), .SeedxDI(seedA),
    .SeedValidxSI(seedValidA), .SeedReadyxSO(seedReadyA),
    .RndxDO(rndA), .RndValidxSO(rndValidA), .RndReadyxSI(rndReadyA),
    .ErrxSO(errA)
  );

  dom_rnd_supplier #(.RND_W(1), .WARMUP_CYC(16), .REPEAT_LIMIT(3)) dutB (
    .ClkxCI(ClkxC), .RstxRI(rstB), .SeedxDI(seedB),
    .SeedValidxSI(seedValidB), .SeedReadyxSO(seedReadyB),
    .RndxDO(rndB), .RndValidxSO(rndValidB), .RndReadyxSI(rndReadyB),
    .ErrxSO(errB)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mS, mSb;
  logic [3:0]  sbA[$];
  logic        mErrB, mPrevB;
  int          mRepB;

  typedef struct {
    logic [31:0] seed;
    int          idle;
    int          nw;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [31:0] mStep(input logic [31:0] s, input int n);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < n; i++) begin
      t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    end
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClkxC);
    #1;
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) begin
      sbA.push_back(mS[3:0]);
      mS = mStep(mS, 4);
    end
  endtask

  // seed handshake, then count cycles until valid rises
  task automatic seedAndWaitA(input logic [31:0] s, input logic rdy,
                              input string name);
    int cyc;
    chk({name, "_seedready"}, 32'(seedReadyA), 32'd1);
    seedA = s;
    seedValidA = 1'b1;
    rndReadyA = rdy;
    tick();
    seedValidA = 1'b0;
    rndReadyA = 1'b0;
    seedA = 32'h0;
    chk({name, "_valid_after_seed"}, 32'(rndValidA), 32'd0);
    sbA.delete();
    mS = (s == 32'h0) ? 32'h1 : s;
    mS = mStep(mS, 4 * 16);
    cyc = 0;
    while (!rndValidA && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({name, "_warmup_cycles"}, 32'(cyc), 32'd16);
  endtask

  task automatic deliverA(input int n, input string name);
    logic [3:0] e;
    rndReadyA = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (sbA.size() == 0) pushWords(1);
      e = sbA.pop_front();
      chk({name, "_valid"}, 32'(rndValidA), 32'd1);
      chk({name, "_word"}, 32'(rndA), 32'(e));
      tick();
    end
    rndReadyA = 1'b0;
  endtask

  task automatic holdA(input int n, input string name);
    if (sbA.size() == 0) pushWords(1);
    for (int i = 0; i < n; i++) begin
      chk({name, "_stable"}, 32'(rndA), 32'(sbA[0]));
      tick();
    end
  endtask

  task automatic modelBitB(input logic b);
    if (mRepB != 0 && b == mPrevB) mRepB++;
    else mRepB = 1;
    mPrevB = b;
`ifdef DOM_RND_HEALTH_EN
    if (mRepB >= 3) mErrB = 1'b1;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic sawValid;
    vecs[0] = '{32'h0000_0000, 10, 5};
    vecs[1] = '{32'hDEAD_BEEF, 3, 4};
    vecs[2] = '{32'h8000_0000, 0, 6};
    vecs[3] = '{32'hFFFF_FFFF, 2, 3};

    rstA = 1'b1; seedA = '0; seedValidA = 1'b0; rndReadyA = 1'b0;
    rstB = 1'b1; seedB = '0; seedValidB = 1'b0; rndReadyB = 1'b0;
    tick();
    tick();
    rstA = 1'b0;
    rstB = 1'b0;
    chk("rst_valid", 32'(rndValidA), 32'd0);
    chk("rst_seedready", 32'(seedReadyA), 32'd1);
    chk("rst_rnd", 32'(rndA), 32'h1);
    chk("rst_err", 32'(errA), 32'd0);

    foreach (vecs[v]) begin
      seedAndWaitA(vecs[v].seed, 1'b0, $sformatf("vec%0d", v));
      holdA(vecs[v].idle, $sformatf("vec%0d", v));
      deliverA(vecs[v].nw, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_err", v), 32'(errA), 32'd0);
    end

    // reseed with a simultaneous consumer handshake
    seedAndWaitA(32'hDEAD_BEEF, 1'b1, "seedwins");
    deliverA(3, "seedwins");

    // reset three cycles into warm-up
    seedA = 32'h1357_9BDF;
    seedValidA = 1'b1;
    tick();
    seedValidA = 1'b0;
    tick();
    tick();
    tick();
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    chk("midrst_valid", 32'(rndValidA), 32'd0);
    chk("midrst_seedready", 32'(seedReadyA), 32'd1);
    chk("midrst_rnd", 32'(rndA), 32'h1);
    sawValid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rndValidA) sawValid = 1'b1;
      tick();
    end
    chk("midrst_no_valid", 32'(sawValid), 32'd0);

    // single-bit instance: repetition health check
    mErrB = 1'b0; mRepB = 0; mPrevB = 1'b0;
    seedB = 32'h1234_5678;
    seedValidB = 1'b1;
    tick();
    seedValidB = 1'b0;
    mSb = mStep(32'h1234_5678, 16);
    cnt = 0;
    while (!rndValidB && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("b_warmup_cycles", 32'(cnt), 32'd16);
    rndReadyB = 1'b1;
    for (int i = 0; i < 40; i++) begin
      chk("b_valid", 32'(rndValidB), 32'(!mErrB));
      chk("b_err", 32'(errB), 32'(mErrB));
      if (!mErrB) chk("b_bit", 32'(rndB), 32'(mSb[0]));
      tick();
      if (!mErrB) begin
        modelBitB(mSb[0]);
        mSb = mStep(mSb, 1);
      end
    end
    rndReadyB = 1'b0;
`ifdef DOM_RND_HEALTH_EN
    chk("b_repeat_hit", 32'(mErrB), 32'd1);
`endif
    chk("b_reseed_ready", 32'(seedReadyB), 32'd1);
    seedB = 32'hCAFE_F00D;
    seedValidB = 1'b1;
    tick();
    seedValidB = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("b_reseed_err", 32'(errB), 32'(mErrB));
    chk("b_reseed_valid", 32'(rndValidB), 32'(!mErrB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dom_rnd_supplier.md
DOM_RND_SUPPLIER -- requirements
Module: dom_rnd_supplier

Interface
REQ-001 SHALL have parameter RND_W, default 4, meaning fresh-randomness bits delivered per handshake (Z plus B for one shared GF(2^2) multiplier, SHARES=2); legal range 1..16.
REQ-002 SHALL have parameter WARMUP_CYC, default 16, meaning LFSR advance cycles after seeding before output is valid; legal range 1..255.
REQ-003 SHALL have parameter REPEAT_LIMIT, default 3, meaning consecutive identical delivered words that raise the health error; legal range 2..15.
REQ-004 ClkxCI  in  1  single clock; all state updates on rising edge.
REQ-005 RstxRI  in  1  reset; synchronous, active-high.
REQ-006 SeedxDI  in  32  seed value.
REQ-007 SeedValidxSI  in  1  seed offered.
REQ-008 SeedReadyxSO  out  1  seed accepted this cycle when high together with SeedValidxSI.
REQ-009 RndxDO  out  RND_W  fresh randomness word.
REQ-010 RndValidxSO  out  1  RndxDO is valid.
REQ-011 RndReadyxSI  in  1  consumer takes RndxDO this cycle when high together with RndValidxSO.
REQ-012 ErrxSO  out  1  sticky health-check failure.

Function
REQ-013 SHALL hold a 32-bit state S; one LFSR step = fb = S[31]^S[21]^S[1]^S[0], S <= {S[30:0], fb}.
REQ-014 "Advance" SHALL mean RND_W LFSR steps applied combinationally in one cycle.
REQ-015 RndxDO SHALL equal S[RND_W-1:0] (registered state, no combinational path from inputs).
REQ-016 FSM states: UNSEEDED, WARMUP, RUN.
REQ-017 UNSEEDED: SeedReadyxSO=1, RndValidxSO=0, S held; seed handshake -> WARMUP.
REQ-018 Seed handshake SHALL load S <= SeedxDI, except SeedxDI==0 loads 0x00000001 (all-zero lock-up prevention).
REQ-019 WARMUP: SeedReadyxSO=0, RndValidxSO=0; S advances every cycle; an 8-bit counter counts WARMUP_CYC advances, then -> RUN.
REQ-020 RUN: RndValidxSO=1, SeedReadyxSO=1; S advances only in cycles where RndValidxSO&RndReadyxSI.
REQ-021 RUN with RndReadyxSI=0: RndxDO SHALL remain stable (no advance, no word skipped).
REQ-022 RUN with seed handshake: seed wins over simultaneous consumer handshake; current word counts as delivered, S reloaded per REQ-018, -> WARMUP, RndValidxSO low from next cycle.
REQ-023 No word SHALL ever be delivered twice: each RUN handshake is followed by an advance before the next valid word.
REQ-024 SeedxDI SHALL be ignored whenever SeedValidxSI=0 or SeedReadyxSO=0.

Reset
REQ-025 RstxRI=1 at a rising edge SHALL force: state UNSEEDED, S=0x00000001, warm-up counter=0, repeat counter=0, ErrxSO=0.
REQ-026 Reset-driven outputs: RndValidxSO=0, SeedReadyxSO=1, RndxDO=S[RND_W-1:0] of 0x00000001.
REQ-027 Reset mid-WARMUP or mid-RUN SHALL abandon the operation; randomness requires a new seed.

Configuration
REQ-028 Macro DOM_RND_HEALTH_EN: when defined, a 4-bit counter compares each delivered word with the previously delivered word; equal increments, differing clears to 1; reaching REPEAT_LIMIT sets ErrxSO sticky until reset; while ErrxSO=1, RndValidxSO SHALL be 0.
REQ-029 Without DOM_RND_HEALTH_EN: no comparator/counter logic, ErrxSO tied 0, behaviour otherwise identical.
REQ-030 Seeding SHALL not clear ErrxSO; only reset does.

Verification
REQ-031 Reset, then seed 0x00000000 -> loaded S=0x00000001; RndValidxSO rises exactly WARMUP_CYC (16) cycles after the seed handshake cycle.
REQ-032 RUN, RndReadyxSI held 0 for 10 cycles -> RndxDO constant, then 5 ready cycles deliver 5 words matching a bit-exact model of REQ-013/014.
REQ-033 RUN, SeedValidxSI and RndReadyxSI high same cycle with SeedxDI=0xDEADBEEF -> RndValidxSO 0 next cycle, S model restarted from 0xDEADBEEF, valid back after 16 cycles.
REQ-034 RstxRI asserted 3 cycles into WARMUP -> next cycle UNSEEDED, RndValidxSO=0, SeedReadyxSO=1, no valid without new seed.
REQ-035 DOM_RND_HEALTH_EN, RND_W=1, REPEAT_LIMIT=3, force state yielding three identical consecutive delivered bits -> ErrxSO=1 sticky, RndValidxSO=0, persists across reseed.
REQ-036 Without DOM_RND_HEALTH_EN, same stimulus -> ErrxSO stays 0, words keep flowing.
